// File: rtl/rs232_input.sv
`default_nettype none
// ============================================================================
// Module   : rs232_input
// Purpose  : 8N1 UART receiver; one-cycle strobes for good bytes / bad frames.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_input #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int          HALF_BIT    = CLKS_PER_BIT / 2;
  localparam logic [14:0] c_half_last = 15'(HALF_BIT - 1);
  localparam logic [14:0] c_bit_last  = 15'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rx_meta, r_rx_s, r_rx_d;
  logic [14:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt, w_err_nxt;
  logic        w_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // Edge-only detect: a line parked low after a frame error cannot retrigger.
  assign w_start = r_rx_d & ~r_rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 15'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      o_data      <= w_data_nxt;
      o_valid     <= w_valid_nxt;
      o_frame_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 15'd1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = o_data;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 15'd0;
        if (w_start) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt     = 15'd0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt   = 15'd0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt   = 15'd0;
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_input
// Purpose  : Self-checking bench for rs232_input against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_input;

  localparam int C      = 16;
  localparam int HALF   = C / 2;
  localparam int STROBE = 2 + HALF + 9 * C;

  typedef struct {
    logic [7:0] d;
    int         t;
  } ev_t;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  ev_t got_v[$], got_e[$], exp_v[$], exp_e[$];
  logic [7:0] last_good;

  rs232_input #(.CLKS_PER_BIT(C)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  always @(posedge i_clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobes are registered, so a pulse seen at this negedge rose on edge edge_n.
  always @(negedge i_clk) begin
    if (o_valid)     got_v.push_back('{d: o_data, t: edge_n});
    if (o_frame_err) got_e.push_back('{d: 8'h00,  t: edge_n});
    if (o_valid || o_frame_err) check("strobe_exclusive", o_valid & o_frame_err, 0);
  end

  task automatic wait_to(input int t);
    while (edge_n < t) @(negedge i_clk);
  endtask

  // Behavioural transmitter plus expectation: called on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int e0;
    e0 = edge_n + 1;
    if (stop) begin
      exp_v.push_back('{d: b, t: e0 + STROBE});
      last_good = b;
    end else begin
      exp_e.push_back('{d: 8'h00, t: e0 + STROBE});
    end
    i_rx = 1'b0;
    repeat (C) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (C) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (C) @(negedge i_clk);
  endtask

  task automatic compare_events(input string tag);
    ev_t g, x;
    check({tag, "_nvalid"}, got_v.size(), exp_v.size());
    check({tag, "_nerr"},   got_e.size(), exp_e.size());
    while (got_v.size() > 0 && exp_v.size() > 0) begin
      g = got_v.pop_front();
      x = exp_v.pop_front();
      check({tag, "_data"},   g.d, x.d);
      check({tag, "_vtime"},  g.t, x.t);
    end
    while (got_e.size() > 0 && exp_e.size() > 0) begin
      g = got_e.pop_front();
      x = exp_e.pop_front();
      check({tag, "_etime"},  g.t, x.t);
    end
    got_v.delete(); got_e.delete(); exp_v.delete(); exp_e.delete();
  endtask

  initial begin
    int   e0;
    logic [7:0] rb;
    logic rs;

    i_rx      = 1'b1;
    i_rst_n   = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_data",  o_data, 8'h00);
    check("rst_valid", o_valid, 0);
    check("rst_err",   o_frame_err, 0);
    check("rst_busy",  o_busy, 0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // Single good byte with cycle-exact strobe timing.
    e0 = edge_n + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_to(e0 + 1);          check("a5_busy_pre", o_busy, 0);
        wait_to(e0 + 2);          check("a5_busy_on",  o_busy, 1);
        wait_to(e0 + STROBE - 1); check("a5_busy_mid", o_busy, 1);
                                  check("a5_no_early", o_valid, 0);
        wait_to(e0 + STROBE);     check("a5_valid",    o_valid, 1);
                                  check("a5_data",     o_data, 8'hA5);
                                  check("a5_busy_off", o_busy, 0);
                                  check("a5_err",      o_frame_err, 0);
        wait_to(e0 + STROBE + 1); check("a5_valid_1cy", o_valid, 0);
      end
    join
    repeat (4) @(negedge i_clk);
    compare_events("a5");

    // Glitch rejection: 4-cycle low pulse.
    e0 = edge_n + 1;
    fork
      begin
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rx = 1'b1;
      end
      begin
        wait_to(e0 + 2);            check("gl_busy_on",  o_busy, 1);
        wait_to(e0 + 1 + HALF);     check("gl_busy_mid", o_busy, 1);
        wait_to(e0 + 2 + HALF);     check("gl_busy_off", o_busy, 0);
      end
    join
    repeat (3 * C) @(negedge i_clk);
    compare_events("glitch");

    // Frame error with the line held low afterwards (break).
    send_frame(8'h11, 1'b1);
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge i_clk);
    check("fe_busy_break", o_busy, 0);
    check("fe_data_hold",  o_data, 8'h11);
    compare_events("ferr");
    i_rx = 1'b1;
    repeat (C) @(negedge i_clk);
    rb = 8'($urandom);
    send_frame(rb, 1'b1);
    repeat (4) @(negedge i_clk);
    compare_events("rearm");

    // Back-to-back frames, zero idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge i_clk);
    compare_events("b2b");
    check("b2b_data", o_data, 8'hFF);

    // Reset in the middle of data bit 3 of 0x5A.
    rb   = 8'h5A;
    i_rx = 1'b0;
    repeat (C) @(negedge i_clk);
    for (int k = 0; k < 4; k++) begin
      i_rx = rb[k];
      repeat ((k == 3) ? HALF : C) @(negedge i_clk);
    end
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    @(negedge i_clk);
    check("mr_data",  o_data, 8'h00);
    check("mr_valid", o_valid, 0);
    check("mr_err",   o_frame_err, 0);
    check("mr_busy",  o_busy, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n   = 1'b1;
    last_good = 8'h00;
    repeat (12 * C) @(negedge i_clk);
    compare_events("abort");
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge i_clk);
    compare_events("post_rst");
    check("post_rst_data", o_data, 8'hC3);

    // Randomised frames, random gaps, occasional bad stop bit.
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs);
      i_rx = 1'b1;
      repeat ($urandom_range(1, 20)) @(negedge i_clk);
    end
    repeat (4) @(negedge i_clk);
    compare_events("rand");
    check("rand_data", o_data, last_good);

    // Loopback sweep of every byte value.
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
    repeat (4) @(negedge i_clk);
    compare_events("loop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs232_input.md
# rs232_input

Byte-wide UART receiver: the receive-side counterpart of the team's UART transmitter. It deserialises an 8N1 serial stream on `i_rx` into parallel bytes. Each good byte is presented as a one-cycle valid strobe, and bad frames as a one-cycle error strobe. It sits between the board RX pin (or a TX loopback in simulation) and the command/FIFO logic. It uses the same bit-period counting scheme as the transmitter, so one `CLKS_PER_BIT` value serves both directions.

## Interface
- `CLKS_PER_BIT`, default 16, 15-bit: i_clk cycles per serial bit; legal range 4..32767. Production value is 25_000_000/9600 = 2604.
- `HALF_BIT`, derived, = CLKS_PER_BIT/2 (integer division): cycles from start detection to the start-bit sample point.
- `i_clk`, in, 1: system clock, 25 MHz.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_rx`, in, 1: asynchronous serial input; idles high.
- `o_data`, out, 8: last correctly received byte, LSB received first. Holds its value until the next good frame.
- `o_valid`, out, 1: one-cycle pulse; `o_data` is new in that same cycle.
- `o_frame_err`, out, 1: one-cycle pulse; the stop bit sampled low.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser.** `i_rx` passes through a 2-FF synchroniser (`rx_s`) followed by one delay register (`rx_d`). All three reset to 1.
- **Start detect.** Fires in IDLE when `rx_d==1 && rx_s==0`, i.e. on a falling edge only. A line held low never retriggers.
- **States:** IDLE, START, DATA, STOP. A 15-bit cycle counter `cnt` and a 3-bit bit index run alongside.
- **IDLE.** On start detect: go to START, `cnt<=0`.
- **START.** Count up. When `cnt==HALF_BIT-1`, sample `rx_s`:
  - 0: go to DATA, `cnt<=0`, bit index <= 0.
  - 1: false start (glitch); return to IDLE with no output pulse.
- **DATA.** Count up. When `cnt==CLKS_PER_BIT-1`:
  - Shift `rx_s` into the MSB of the shift register (right shift), so the byte ends up LSB-first.
  - Set `cnt<=0`.
  - After the 8th bit (index 7), go to STOP; otherwise increment the bit index.
- **STOP.** When `cnt==CLKS_PER_BIT-1`, sample `rx_s`:
  - 1: `o_data<=` shift register, `o_valid<=1`.
  - 0: `o_frame_err<=1`; `o_data` is unchanged.
  - In both cases go to IDLE.
- **Re-arm.** Returning to IDLE at mid-stop-bit lets a back-to-back start bit (half a bit later) be detected. After a frame error, the edge detector blocks re-arm until the line has returned high and then fallen again (break handling).
- **Strobes.** `o_valid` and `o_frame_err` are registered, last one cycle, and are never high together.
- **Counter width.** `cnt` is 15-bit and compares only with `==`. It never exceeds `CLKS_PER_BIT-1`, so there is no wrap.
- **Reset mid-frame.** Takes effect immediately:
  - FSM goes to IDLE; counters and shift register clear.
  - Synchroniser and delay registers go to 1.
  - The partial byte is discarded with no pulse.
  - If `i_rx` is low when reset releases, nothing is received until a 1→0 transition occurs.

## Timing
- **Reset values:** `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0. Internal `rx_s`/`rx_d`=1.
- **Reference edge.** Let e0 be the first i_clk edge that samples `i_rx` low.
  - START is entered at e0+2; `o_busy` is high from e0+2.
  - Start-bit sample at e0+2+HALF_BIT.
  - Data bit k (k=0..7) sampled at e0+2+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - Stop sample at e0+2+HALF_BIT+9·CLKS_PER_BIT; `o_valid`/`o_frame_err` rise on that edge, and `o_busy` falls on it.
- **CLKS_PER_BIT=16:** the strobe is high for the cycle after edge e0+154.
- **False start:** `o_busy` falls at e0+2+HALF_BIT.
- **Throughput:** one byte per 10·CLKS_PER_BIT cycles with zero idle gap between frames.

## Test plan
- **Single good byte.** CLKS_PER_BIT=16; drive 0xA5 as 8N1 with 16-cycle bits → `o_data`=0xA5 and `o_valid` high exactly one cycle after edge e0+154; `o_frame_err` stays 0.
- **Glitch rejection.** Pulse `i_rx` low for 4 cycles, then hold high → `o_busy` high at e0+2 and low at e0+10; no `o_valid` or `o_frame_err` ever.
- **Frame error.** First receive 0x11 good; then send 0x3C with the stop bit low and hold the line low for 40 cycles → `o_frame_err` one-cycle pulse, `o_data` stays 0x11, and no new start while the line stays low; the line rising then falling starts a new frame.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap → two `o_valid` pulses 160 cycles apart carrying 0x00 and 0xFF.
- **Reset mid-frame.** Assert `i_rst_n` low during data bit 3 of 0x5A, release it, then send 0xC3 → all outputs are 0 during reset, no pulse for the aborted frame, and 0xC3 is received correctly.
- **Loopback.** Connect the team's UART transmitter (bit period 16) to `i_rx` and send bytes 0x00..0xFF → every byte is received equal to the byte sent; zero frame errors.
